// File: rtl/fpga_stream_source.sv
// CSR-controlled word buffer: single-word read/write through the CSR window and
// an AXI-stream dump engine that streams LEN consecutive words with wraparound.
module fpga_stream_source #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        avs_address,
    input  logic              avs_chipselect,
    input  logic              avs_write_n,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [DATA_W-1:0] axis_m_tdata,
    output logic              axis_m_tvalid,
    output logic              axis_m_tlast,
    input  logic              axis_m_tready
);
    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, DUMP = 2'd2} state_t;
    localparam logic [ADDR_W:0]   ONE  = 1;
    localparam logic [ADDR_W-1:0] AONE = 1;

    state_t              state;
    logic                go, abort, clr_cnt, err;
    logic [1:0]          op;
    logic [ADDR_W-1:0]   addr, cur, cur_nxt;
    logic [DATA_W-1:0]   wdata, rdata, mem_q;
    logic [ADDR_W:0]     cfg, len, rem;
    logic [31:0]         beat_cnt;
    logic                csr_wr, busy, hs, ld, mem_we, unused_ok;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    assign csr_wr    = avs_chipselect & ~avs_write_n;
    assign busy      = (state != IDLE);
    assign hs        = axis_m_tvalid & axis_m_tready;
    assign ld        = (state == DUMP) && (rem != '0) &&
                       (!axis_m_tvalid || (axis_m_tready && !axis_m_tlast));
    assign mem_we    = go && (state == IDLE) && (op == 2'b01);
    assign unused_ok = ^avs_writedata;

    always_comb begin
        len = cfg;
        if (cfg == '0) len[ADDR_W] = 1'b1;
    end

    // The read port is addressed with the next fetch pointer so mem_q always
    // holds the word for the next beat to be loaded, giving one beat per cycle.
    always_comb begin
        cur_nxt = cur;
        if (go && state == IDLE) cur_nxt = addr;
        else if (ld)             cur_nxt = cur + AONE;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= wdata;
        mem_q <= mem[cur_nxt];
    end

    // A CSR write to CTRL takes precedence over the self-clear of the pulse bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            go <= 1'b0; abort <= 1'b0; clr_cnt <= 1'b0; op <= '0; addr <= '0;
            wdata <= '0; cfg <= '0;
        end else begin
            if (csr_wr && avs_address == 3'd0) begin
                go      <= avs_writedata[0];
                op      <= avs_writedata[2:1];
                addr    <= avs_writedata[4 +: ADDR_W];
                abort   <= avs_writedata[30];
                clr_cnt <= avs_writedata[31];
            end else begin
                go <= 1'b0; abort <= 1'b0; clr_cnt <= 1'b0;
            end
            if (csr_wr && avs_address == 3'd2) wdata <= avs_writedata[DATA_W-1:0];
            if (csr_wr && avs_address == 3'd4) cfg   <= avs_writedata[ADDR_W:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE; cur <= '0; rem <= '0; rdata <= '0; err <= 1'b0;
            beat_cnt <= '0;
            axis_m_tvalid <= 1'b0; axis_m_tlast <= 1'b0; axis_m_tdata <= '0;
        end else begin
            cur <= cur_nxt;
            if (clr_cnt)  beat_cnt <= '0;
            else if (hs)  beat_cnt <= beat_cnt + 32'd1;
            if (go && (busy || op == 2'b11))
                err <= 1'b1;
            else if (csr_wr && avs_address == 3'd1 && avs_writedata[1])
                err <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    if (op == 2'b00) state <= RD_WAIT;
                    else if (op == 2'b10) begin
                        state <= DUMP;
                        rem   <= len;
                    end
                end
                RD_WAIT: begin
                    rdata <= mem_q;
                    state <= IDLE;
                end
                DUMP: begin
                    if (ld) begin
                        axis_m_tvalid <= 1'b1;
                        axis_m_tdata  <= mem_q;
                        axis_m_tlast  <= (rem == ONE) || abort;
                        rem           <= rem - ONE;
                    end else if (hs) begin
                        axis_m_tvalid <= 1'b0;
                        axis_m_tlast  <= 1'b0;
                        state         <= IDLE;
                    end else if (abort && axis_m_tvalid) begin
                        // abort while stalled: the presented beat becomes the last one
                        axis_m_tlast <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            3'd0: begin
                avs_readdata[0]           = go;
                avs_readdata[2:1]         = op;
                avs_readdata[4 +: ADDR_W] = addr;
                avs_readdata[30]          = abort;
                avs_readdata[31]          = clr_cnt;
            end
            3'd1: begin
                avs_readdata[0]           = busy;
                avs_readdata[1]           = err;
                avs_readdata[3:2]         = state;
                avs_readdata[4 +: ADDR_W] = cur;
            end
            3'd2:    avs_readdata[DATA_W-1:0] = wdata;
            3'd3:    avs_readdata[DATA_W-1:0] = rdata;
            3'd4:    avs_readdata[ADDR_W:0]   = cfg;
            3'd5:    avs_readdata             = beat_cnt;
            default: avs_readdata             = '1;
        endcase
    end
endmodule

// File: tb/tb_fpga_stream_source.sv
// Directed sequence with randomized data and stall patterns, checked against a
// shadow buffer and an expected-stream model built from the dump rules.
module tb_fpga_stream_source;
    localparam int DW = 8, AW = 12, DEPTH = 1 << AW;

    logic          clk = 1'b0, reset = 1'b1;
    logic [2:0]    avs_address = '0;
    logic          avs_chipselect = 1'b0, avs_write_n = 1'b1;
    logic [31:0]   avs_writedata = '0, avs_readdata;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast, tready = 1'b0;

    fpga_stream_source #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_chipselect(avs_chipselect),
        .avs_write_n(avs_write_n), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .axis_m_tdata(tdata), .axis_m_tvalid(tvalid), .axis_m_tlast(tlast),
        .axis_m_tready(tready)
    );

    always #5 clk = ~clk;

    int            checks = 0, errors = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_ok  [DEPTH];
    logic [DW-1:0] last_rd = '0;
    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    int            hs_n = 0;
    bit            stab_en = 1'b0;
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor on the falling edge: captures handshakes and checks that a
    // stalled beat is held unchanged.
    always @(negedge clk) begin
        if (stab_en && pv && !pr) begin
            chk("stall_valid", {31'b0, tvalid}, 32'd1);
            chk("stall_data", 32'(tdata), 32'(pd));
            chk("stall_last", {31'b0, tlast}, {31'b0, pl});
        end
        if (tvalid && tready) begin
            got_d.push_back(tdata);
            got_l.push_back(tlast);
            hs_n++;
        end
        pv = tvalid; pr = tready; pd = tdata; pl = tlast;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_chipselect = 1'b1; avs_write_n = 1'b0;
        @(posedge clk); #1;
        avs_chipselect = 1'b0; avs_write_n = 1'b1;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; #1;
        d = avs_readdata;
    endtask

    task automatic buf_wr(input int a, input logic [DW-1:0] d);
        csr_wr(3'd2, 32'(d));
        csr_wr(3'd0, 32'(a << 4) | 32'h3);
        ref_mem[a] = d;
        ref_ok[a]  = 1'b1;
    endtask

    task automatic read_chk(input int a);
        logic [31:0] s;
        csr_wr(3'd0, 32'(a << 4) | 32'h1);
        csr_rd(3'd0, s);  chk("rd_go_set", {31'b0, s[0]}, 32'd1);
        tick();
        csr_rd(3'd1, s);  chk("rd_t1_stat", {28'b0, s[3:0]}, 32'h5);
        chk("rd_t1_addr", {20'b0, s[15:4]}, 32'(a));
        csr_rd(3'd3, s);  chk("rd_t1_rdata_old", s, 32'(last_rd));
        csr_rd(3'd0, s);  chk("rd_go_cleared", {31'b0, s[0]}, 32'd0);
        tick();
        csr_rd(3'd3, s);  chk("rd_t2_rdata", s, 32'(ref_mem[a]));
        csr_rd(3'd1, s);  chk("rd_t2_busy", {31'b0, s[0]}, 32'd0);
        last_rd = ref_mem[a];
    endtask

    task automatic start_dump(input int base, input int cfg, input bit rnd);
        logic [31:0] s;
        csr_wr(3'd4, 32'(cfg));
        got_d.delete(); got_l.delete(); hs_n = 0;
        tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        csr_wr(3'd0, 32'(base << 4) | 32'h5);
        chk("dump_t0_valid", {31'b0, tvalid}, 32'd0);
        tick();
        csr_rd(3'd1, s);
        chk("dump_t1_stat", {28'b0, s[3:0]}, 32'h9);
        chk("dump_t1_valid", {31'b0, tvalid}, 32'd0);
        tick();
        chk("dump_t2_valid", {31'b0, tvalid}, 32'd1);
    endtask

    task automatic wait_done(input bit rnd, input int bound);
        logic [31:0] s;
        int n = 0;
        forever begin
            csr_rd(3'd1, s);
            if (!s[0]) begin
                chk("valid_drops_with_busy", {31'b0, tvalid}, 32'd0);
                break;
            end
            if (n >= bound) begin
                chk("done_timeout", {31'b0, s[0]}, 32'd0);
                break;
            end
            n++;
            if (rnd) tready = 1'($urandom_range(0, 1));
            tick();
        end
        tready = 1'b1;
    endtask

    // Expected stream: word (base+k) mod depth, tlast only on the final beat.
    task automatic cmp_stream(input int base, input int len);
        foreach (got_d[k]) begin
            int ad = (base + k) % DEPTH;
            if (ref_ok[ad]) chk($sformatf("beat%0d_data", k), 32'(got_d[k]), 32'(ref_mem[ad]));
            chk($sformatf("beat%0d_last", k), {31'b0, got_l[k]}, {31'b0, k == len - 1});
        end
    endtask

    initial begin
        logic [31:0] s;
        int n, n0, base, lasts;

        repeat (3) tick();
        chk("rst_tvalid", {31'b0, tvalid}, 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        csr_rd(3'd1, s); chk("rst_stat", s, 32'd0);
        csr_rd(3'd5, s); chk("rst_beat_cnt", s, 32'd0);
        csr_rd(3'd0, s); chk("rst_ctrl", s, 32'd0);
        reset = 1'b0;
        tick();

        csr_rd(3'd6, s); chk("csr6_ones", s, 32'hFFFF_FFFF);
        csr_wr(3'd7, 32'h0);
        csr_rd(3'd7, s); chk("csr7_ones", s, 32'hFFFF_FFFF);
        csr_wr(3'd4, 32'd5);
        csr_rd(3'd4, s); chk("dump_cfg_rb", s, 32'd5);
        csr_wr(3'd2, 32'h1C3);
        csr_rd(3'd2, s); chk("wdata_rb", s, 32'hC3);

        for (int a = 0; a < 128; a++) buf_wr(a, 8'($urandom_range(0, 255)));

        buf_wr(16, 8'hA5);
        tick();
        read_chk(16);
        for (int i = 0; i < 5; i++) read_chk($urandom_range(0, 127));

        csr_wr(3'd0, 32'h4000_0000);
        tick();
        csr_rd(3'd1, s); chk("abort_idle_noop", {28'b0, s[3:0]}, 32'h0);

        // wrapping dump across the top of the buffer
        buf_wr(DEPTH - 2, 8'hFE); buf_wr(DEPTH - 1, 8'hFF);
        buf_wr(0, 8'h00); buf_wr(1, 8'h01);
        tick();
        stab_en = 1'b1;
        start_dump(DEPTH - 2, 4, 1'b0);
        wait_done(1'b0, 50);
        chk("wrap_count", 32'(got_d.size()), 32'd4);
        cmp_stream(DEPTH - 2, 4);
        csr_rd(3'd5, s); chk("wrap_beat_cnt", s, 32'd4);

        for (int r = 0; r < 3; r++) begin
            base = $urandom_range(0, 119);
            start_dump(base, 8, 1'b1);
            wait_done(1'b1, 400);
            chk("bp_count", 32'(got_d.size()), 32'd8);
            cmp_stream(base, 8);
        end

        // error paths while a dump is running
        start_dump(8, 40, 1'b0);
        csr_wr(3'd0, 32'(200 << 4) | 32'h5);
        tick();
        csr_rd(3'd1, s); chk("err_go_busy", {31'b0, s[1]}, 32'd1);
        csr_wr(3'd1, 32'h2);
        csr_rd(3'd1, s); chk("err_clear", {31'b0, s[1]}, 32'd0);
        csr_wr(3'd2, 32'h5A);
        csr_wr(3'd0, 32'(45 << 4) | 32'h3);
        tick();
        csr_rd(3'd1, s); chk("err_bufwr_dump", {31'b0, s[1]}, 32'd1);
        csr_wr(3'd1, 32'h2);
        wait_done(1'b0, 200);
        chk("err_dump_count", 32'(got_d.size()), 32'd40);
        cmp_stream(8, 40);

        csr_wr(3'd0, 32'h7);
        tick();
        csr_rd(3'd1, s); chk("err_type11", {28'b0, s[3:0]}, 32'h2);
        csr_wr(3'd1, 32'h2);
        csr_rd(3'd1, s); chk("err_type11_clear", {31'b0, s[1]}, 32'd0);

        // counter clear coinciding with a handshake
        start_dump(50, 20, 1'b0);
        repeat (3) tick();
        csr_wr(3'd0, 32'h8000_0000);
        tick();
        csr_rd(3'd5, s); chk("clr_wins", s, 32'd0);
        n0 = hs_n;
        csr_rd(3'd0, s); chk("clr_self_clear", {31'b0, s[31]}, 32'd0);
        wait_done(1'b0, 100);
        csr_rd(3'd5, s); chk("cnt_after_clr", s, 32'(hs_n - n0));

        // abort after 10 handshakes
        stab_en = 1'b0;
        start_dump(0, 100, 1'b0);
        n = 0;
        while (hs_n < 10 && n < 300) begin tick(); n++; end
        chk("abort_reached_10", {31'b0, hs_n >= 10}, 32'd1);
        tready = 1'b0;
        csr_wr(3'd0, 32'h4000_0000);
        tick();
        tready = 1'b1;
        wait_done(1'b0, 300);
        chk("abort_max12", {31'b0, got_d.size() <= 12}, 32'd1);
        chk("abort_last_tlast", {31'b0, got_l[got_l.size() - 1]}, 32'd1);
        cmp_stream(0, got_d.size());
        csr_rd(3'd1, s); chk("abort_busy", {31'b0, s[0]}, 32'd0);

        // LEN = 0 streams the whole buffer
        start_dump(0, 0, 1'b0);
        wait_done(1'b0, DEPTH + 50);
        chk("len0_count", 32'(got_d.size()), 32'(DEPTH));
        lasts = 0;
        foreach (got_l[k]) lasts += int'(got_l[k]);
        chk("len0_single_last", 32'(lasts), 32'd1);
        chk("len0_last_pos", {31'b0, got_l[got_l.size() - 1]}, 32'd1);
        for (int k = 0; k < 128; k++) chk("len0_data", 32'(got_d[k]), 32'(ref_mem[k]));

        // reset during a dump
        start_dump(20, 50, 1'b0);
        n = 0;
        while (hs_n < 5 && n < 100) begin tick(); n++; end
        reset = 1'b1;
        #1;
        chk("rst_async_tvalid", {31'b0, tvalid}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        csr_rd(3'd1, s); chk("post_rst_stat", s, 32'd0);
        csr_rd(3'd5, s); chk("post_rst_beat_cnt", s, 32'd0);
        n0 = hs_n;
        repeat (20) tick();
        chk("post_rst_no_beats", 32'(hs_n), 32'(n0));
        chk("post_rst_tvalid", {31'b0, tvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
